// File: rtl/reg_file_16x16_if.sv
// Register-file access bus: decode supplies addresses, writeback supplies results,
// and the file returns operands plus the always-visible R0 value.
interface reg_file_16x16_if;
  logic [1:0]  RegWrite;
  logic [3:0]  ReadReg1;
  logic [3:0]  ReadReg2;
  logic [3:0]  WriteReg1;
  logic [3:0]  WriteReg2;
  logic [15:0] WriteData1;
  logic [15:0] WriteData2;
  logic [15:0] ReadData1;
  logic [15:0] ReadData2;
  logic [15:0] RegZeroData;

  modport master (
    output RegWrite, ReadReg1, ReadReg2, WriteReg1, WriteReg2, WriteData1, WriteData2,
    input  ReadData1, ReadData2, RegZeroData
  );

  modport slave (
    input  RegWrite, ReadReg1, ReadReg2, WriteReg1, WriteReg2, WriteData1, WriteData2,
    output ReadData1, ReadData2, RegZeroData
  );
endinterface

// File: rtl/reg_file_16x16.sv
// Sixteen 16-bit architectural registers with two combinational read ports and
// two edge-committed write ports; R0 is additionally exported as RegZeroData.
module reg_file_16x16 (
  input  logic             CLOCK,
  input  logic             RESET,
  reg_file_16x16_if.slave  bus
);

  typedef enum logic [1:0] {
    WR_NONE     = 2'b00,
    WR_PORT1    = 2'b01,
    WR_BOTH     = 2'b10,
    WR_RESERVED = 2'b11
  } write_mode_t;

  logic [15:0] regs [16];
  write_mode_t write_mode;
  logic        write_en1;
  logic        write_en2;

  // Port 2 is suppressed on an address collision so port 1's data wins.
  always_comb begin
    write_mode = write_mode_t'(bus.RegWrite);
    write_en1  = 1'b0;
    write_en2  = 1'b0;
    case (write_mode)
      WR_PORT1: write_en1 = 1'b1;
      WR_BOTH: begin
        write_en1 = 1'b1;
        write_en2 = (bus.WriteReg2 != bus.WriteReg1);
      end
      default: begin
        write_en1 = 1'b0;
        write_en2 = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= 16'h0000;
      end
    end else begin
      if (write_en1) begin
        regs[bus.WriteReg1] <= bus.WriteData1;
      end
      if (write_en2) begin
        regs[bus.WriteReg2] <= bus.WriteData2;
      end
    end
  end

  // Reads come straight from stored state: no write-through bypass.
  assign bus.ReadData1   = regs[bus.ReadReg1];
  assign bus.ReadData2   = regs[bus.ReadReg2];
  assign bus.RegZeroData = regs[0];

endmodule

// File: tb/tb_reg_file_16x16.sv
// Directed self-checking bench for reg_file_16x16 with hand-computed expectations.
module tb_reg_file_16x16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  reg_file_16x16_if bus ();

  reg_file_16x16 dut (
    .CLOCK (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one write request, commit it on the next rising edge, then go idle.
  task automatic applyStimulus(input logic [1:0] rw, input logic [3:0] wr1, input logic [15:0] wd1,
                               input logic [3:0] wr2, input logic [15:0] wd2);
    bus.RegWrite   = rw;
    bus.WriteReg1  = wr1;
    bus.WriteData1 = wd1;
    bus.WriteReg2  = wr2;
    bus.WriteData2 = wd2;
    @(posedge clk);
    @(negedge clk);
    bus.RegWrite = 2'b00;
  endtask

  task automatic readPorts(input logic [3:0] a1, input logic [3:0] a2);
    bus.ReadReg1 = a1;
    bus.ReadReg2 = a2;
    #1;
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    bus.RegWrite   = 2'b00;
    bus.ReadReg1   = 4'd0;
    bus.ReadReg2   = 4'd0;
    bus.WriteReg1  = 4'd0;
    bus.WriteReg2  = 4'd0;
    bus.WriteData1 = 16'h0000;
    bus.WriteData2 = 16'h0000;

    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    readPorts(4'd3, 4'd11);
    checkOutput("reset_rd1_r3", bus.ReadData1, 16'h0000);
    checkOutput("reset_rd2_r11", bus.ReadData2, 16'h0000);
    readPorts(4'd5, 4'd14);
    checkOutput("reset_rd1_r5", bus.ReadData1, 16'h0000);
    checkOutput("reset_rd2_r14", bus.ReadData2, 16'h0000);
    checkOutput("reset_r0", bus.RegZeroData, 16'h0000);

    // Before the edge the pending write must not be visible.
    readPorts(4'd8, 4'd2);
    bus.RegWrite   = 2'b01;
    bus.WriteReg1  = 4'd8;
    bus.WriteData1 = 16'hC78A;
    #1;
    checkOutput("no_bypass_r8", bus.ReadData1, 16'h0000);
    applyStimulus(2'b01, 4'd8, 16'hC78A, 4'd2, 16'h5555);
    readPorts(4'd8, 4'd2);
    checkOutput("wr1_r8", bus.ReadData1, 16'hC78A);
    checkOutput("wr1_ignores_r2", bus.ReadData2, 16'h0000);

    applyStimulus(2'b10, 4'd3, 16'h3251, 4'd0, 16'hAABB);
    readPorts(4'd3, 4'd0);
    checkOutput("dual_r3", bus.ReadData1, 16'h3251);
    checkOutput("dual_r0", bus.ReadData2, 16'hAABB);
    checkOutput("dual_regzero", bus.RegZeroData, 16'hAABB);

    applyStimulus(2'b11, 4'd4, 16'h1234, 4'd6, 16'h6666);
    readPorts(4'd4, 4'd6);
    checkOutput("reserved_r4", bus.ReadData1, 16'h0000);
    checkOutput("reserved_r6", bus.ReadData2, 16'h0000);
    readPorts(4'd8, 4'd3);
    checkOutput("reserved_keeps_r8", bus.ReadData1, 16'hC78A);
    checkOutput("reserved_keeps_r3", bus.ReadData2, 16'h3251);

    applyStimulus(2'b01, 4'd7, 16'h0707, 4'd9, 16'h0909);
    readPorts(4'd7, 4'd9);
    checkOutput("port1_only_r7", bus.ReadData1, 16'h0707);
    checkOutput("port1_only_r9", bus.ReadData2, 16'h0000);

    applyStimulus(2'b00, 4'd10, 16'hDEAD, 4'd11, 16'hBEEF);
    readPorts(4'd10, 4'd11);
    checkOutput("none_r10", bus.ReadData1, 16'h0000);
    checkOutput("none_r11", bus.ReadData2, 16'h0000);

    applyStimulus(2'b10, 4'd5, 16'h1111, 4'd5, 16'h2222);
    readPorts(4'd5, 4'd5);
    checkOutput("collide_r5_p1", bus.ReadData1, 16'h1111);
    checkOutput("collide_r5_p2", bus.ReadData2, 16'h1111);

    applyStimulus(2'b10, 4'd15, 16'hBEEF, 4'd1, 16'h0101);
    readPorts(4'd15, 4'd1);
    checkOutput("dual_r15", bus.ReadData1, 16'hBEEF);
    checkOutput("dual_r1", bus.ReadData2, 16'h0101);
    checkOutput("regzero_unchanged", bus.RegZeroData, 16'hAABB);

    // Reset wins over a simultaneous write.
    rst = 1'b1;
    applyStimulus(2'b01, 4'd8, 16'hFFFF, 4'd0, 16'h0000);
    readPorts(4'd3, 4'd8);
    checkOutput("rst_prio_r3", bus.ReadData1, 16'h0000);
    checkOutput("rst_prio_r8", bus.ReadData2, 16'h0000);
    checkOutput("rst_prio_r0", bus.RegZeroData, 16'h0000);

    applyStimulus(2'b10, 4'd0, 16'h7777, 4'd15, 16'h8888);
    readPorts(4'd0, 4'd15);
    checkOutput("rst_hold_r0", bus.ReadData1, 16'h0000);
    checkOutput("rst_hold_r15", bus.ReadData2, 16'h0000);
    checkOutput("rst_hold_regzero", bus.RegZeroData, 16'h0000);

    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    readPorts(4'd3, 4'd8);
    checkOutput("post_rst_r3", bus.ReadData1, 16'h0000);
    checkOutput("post_rst_r8", bus.ReadData2, 16'h0000);
    checkOutput("post_rst_r0", bus.RegZeroData, 16'h0000);

    applyStimulus(2'b01, 4'd0, 16'h4242, 4'd0, 16'h0000);
    readPorts(4'd0, 4'd5);
    checkOutput("post_rst_wr_r0", bus.ReadData1, 16'h4242);
    checkOutput("post_rst_regzero", bus.RegZeroData, 16'h4242);
    checkOutput("post_rst_r5", bus.ReadData2, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
